// File: rtl/clk_meter_pkg.sv
// Shared types and helpers for the clock period meter.
// State encoding, counter width and a small distance helper used by the
// optional lock detector (CLK_PERIOD_METER_LOCK_EN).
package clk_meter_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } meter_state_e;

  // Unsigned distance between two counts, no wrap-around.
  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a history flop and rising-edge detect.
// Reusable for any slow asynchronous level input; the input must hold each
// level for at least two clk_i cycles for every edge to be seen.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Resynchronize the input and keep one cycle of history for edge detect.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/clk_period_meter.sv
// Clock period meter: counts reference-clock cycles between rising edges of
// a slow asynchronous clock, reports each completed period and flags loss
// of that clock after TIMEOUT cycles without an edge.
// Optional lock detector is compiled in when CLK_PERIOD_METER_LOCK_EN is
// defined; otherwise locked_o is tied low and no lock logic exists.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT    = 32'd1024
`ifdef CLK_PERIOD_METER_LOCK_EN
  ,
  parameter logic [CNT_W-1:0] EXP_PERIOD = 32'd20,
  parameter logic [CNT_W-1:0] TOL        = 32'd1,
  parameter logic [CNT_W-1:0] LOCK_COUNT = 32'd4
`endif
) (
  input  logic             clk_in_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             meas_clk_i,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid_o,
  output logic             timeout_o,
  output logic             locked_o
);

  // Last count value before the clock is declared lost.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT - CNT_W'(1);

  meter_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] period_q;
  logic             valid_q;
  logic             timeout_q;
  logic             rise;
  logic             timeout_hit;

  sync_edge_det u_sync (
    .clk_i   (clk_in_i),
    .rst_ni  (rst_n_i),
    .async_i (meas_clk_i),
    .rise_o  (rise)
  );

  assign cnt_d = cnt_q + CNT_W'(1);

  // A coincident edge beats the timeout, so an exact-TIMEOUT period is valid.
  assign timeout_hit = en_i && (state_q == MEASURE) && !rise && (cnt_q == TIMEOUT_LAST);

  // Measurement FSM, period counter and registered period/timeout outputs.
  always_ff @(posedge clk_in_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!en_i) begin
        // period and timeout keep their last values while disabled
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            // first edge only starts a period; the partial one is discarded
            cnt_q <= '0;
            if (rise) state_q <= MEASURE;
          end
          MEASURE: begin
            if (rise) begin
              period_q <= cnt_d;
              valid_q  <= 1'b1;
              cnt_q    <= '0;
            end else if (timeout_hit) begin
              state_q   <= LOST;
              timeout_q <= 1'b1;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          LOST: begin
            // the recovering edge only restarts measurement, nothing reported
            cnt_q <= '0;
            if (rise) begin
              timeout_q <= 1'b0;
              state_q   <= MEASURE;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign period_o       = period_q;
  assign period_valid_o = valid_q;
  assign timeout_o      = timeout_q;

`ifdef CLK_PERIOD_METER_LOCK_EN
  logic [CNT_W-1:0] match_q;
  logic             locked_q;
  logic             in_tol;

  assign in_tol = (abs_diff(period_q, EXP_PERIOD) <= TOL);

  // Count consecutive in-tolerance periods; any miss, loss or disable resets.
  always_ff @(posedge clk_in_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      match_q  <= '0;
      locked_q <= 1'b0;
    end else if (!en_i || timeout_hit) begin
      match_q  <= '0;
      locked_q <= 1'b0;
    end else if (valid_q) begin
      if (in_tol) begin
        if (match_q >= LOCK_COUNT - CNT_W'(1)) locked_q <= 1'b1;
        // saturate so a long locked run cannot wrap the counter
        if (match_q < LOCK_COUNT) match_q <= match_q + CNT_W'(1);
      end else begin
        match_q  <= '0;
        locked_q <= 1'b0;
      end
    end
  end

  assign locked_o = locked_q;
`else
  assign locked_o = 1'b0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter (TIMEOUT=64). Stimulus pushes the
// period each meas_clk edge is required to report; a monitor pops and
// compares on every period_valid pulse, including the spacing between pulses.
module tb_clk_period_meter;

  logic        clk_in;
  logic        rst_n;
  logic        en;
  logic        meas_clk;
  logic [31:0] period_o;
  logic        period_valid_o;
  logic        timeout_o;
  logic        locked_o;

  typedef struct {
    int unsigned len;
    bit          gap_chk;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          vectors;
  int          errors;
  int          valid_count;
  int unsigned cyc;
  int unsigned last_cyc;

  // stimulus-side model of what the next edge will report
  bit          pend_ok;
  int unsigned pend_len;
  bit          start_valid;

  clk_period_meter #(
    .TIMEOUT(32'd64)
`ifdef CLK_PERIOD_METER_LOCK_EN
    ,
    .EXP_PERIOD(32'd20),
    .TOL(32'd1),
    .LOCK_COUNT(32'd4)
`endif
  ) dut (
    .clk_in_i       (clk_in),
    .rst_n_i        (rst_n),
    .en_i           (en),
    .meas_clk_i     (meas_clk),
    .period_o       (period_o),
    .period_valid_o (period_valid_o),
    .timeout_o      (timeout_o),
    .locked_o       (locked_o)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // One meas_clk period: rising edge, hi cycles high, lo cycles low.
  task automatic wave(input int hi, input int lo);
    if (pend_ok) exp_q.push_back('{pend_len, start_valid});
    start_valid = pend_ok;
    pend_ok     = en;
    pend_len    = hi + lo;
    meas_clk    = 1'b1;
    repeat (hi) tick();
    meas_clk = 1'b0;
    repeat (lo) tick();
  endtask

  // Monitor: every period_valid pulse is one transaction against the queue.
  always @(negedge clk_in) begin
    if (period_valid_o) begin
      valid_count++;
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: period=%0d reported, no report required", period_o);
      end else begin
        mon_e = exp_q.pop_front();
        $display("txn %0d: period=%0d required=%0d gap=%0d", valid_count, period_o, mon_e.len,
                 cyc - last_cyc);
        if (period_o !== mon_e.len) begin
          errors++;
          $display("FAIL period: got %0d, required %0d", period_o, mon_e.len);
        end
        if (mon_e.gap_chk) begin
          vectors++;
          if (cyc - last_cyc != mon_e.len) begin
            errors++;
            $display("FAIL valid_spacing: got %0d, required %0d", cyc - last_cyc, mon_e.len);
          end
        end
      end
      last_cyc = cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int vc;
    vectors     = 0;
    errors      = 0;
    valid_count = 0;
    cyc         = 0;
    last_cyc    = 0;
    pend_ok     = 0;
    pend_len    = 0;
    start_valid = 0;
    rst_n       = 1'b0;
    en          = 1'b0;
    meas_clk    = 1'b0;
    repeat (3) tick();
    check("reset_period", period_o, 0);
    check("reset_valid", 32'(period_valid_o), 0);
    check("reset_timeout", 32'(timeout_o), 0);
    check("reset_locked", 32'(locked_o), 0);
    rst_n = 1'b1;
    tick();

    // disabled: edges must produce nothing
    vc = valid_count;
    repeat (3) wave(10, 10);
    check("disabled_no_valid", 32'(valid_count - vc), 0);

    // steady divider, CLOCK_DIVISOR=10 -> period 20
    en = 1'b1;
    tick();
    repeat (6) wave(10, 10);

    // minimum pulse widths -> period 4
    repeat (5) wave(2, 2);

    // exact-TIMEOUT period: edge coincides with cnt==63
    wave(32, 32);
    wave(32, 32);
    wave(2, 2);
    check("boundary_no_timeout", 32'(timeout_o), 0);

    // loss of clock: one reported edge, then silence
    if (pend_ok) exp_q.push_back('{pend_len, start_valid});
    start_valid = pend_ok;
    pend_ok     = 1'b0;
    meas_clk    = 1'b1;
    found       = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (period_valid_o) found = 1'b1;
    end
    check("valid_before_loss", 32'(found), 1);
    meas_clk = 1'b0;
    repeat (63) tick();
    check("timeout_not_early", 32'(timeout_o), 0);
    tick();
    check("timeout_asserted", 32'(timeout_o), 1);
    check("locked_on_timeout", 32'(locked_o), 0);
    repeat (10) tick();
    check("timeout_held", 32'(timeout_o), 1);

    // restart: first edge clears timeout only, then full periods report
    wave(10, 10);
    check("timeout_cleared", 32'(timeout_o), 0);
    wave(10, 10);
    wave(10, 10);

    // asynchronous reset in the middle of a period
    if (pend_ok) exp_q.push_back('{pend_len, start_valid});
    start_valid = pend_ok;
    meas_clk    = 1'b1;
    repeat (5) tick();
    check("pre_reset_period", period_o, 20);
    rst_n = 1'b0;
    #1;
    check("midreset_period", period_o, 0);
    check("midreset_valid", 32'(period_valid_o), 0);
    check("midreset_timeout", 32'(timeout_o), 0);
    check("midreset_locked", 32'(locked_o), 0);
    meas_clk = 1'b0;
    repeat (3) tick();
    pend_ok     = 1'b0;
    start_valid = 1'b0;
    en          = 1'b0;
    rst_n       = 1'b1;
    tick();
    vc = valid_count;
    repeat (2) wave(10, 10);
    check("en_low_no_valid", 32'(valid_count - vc), 0);
    en = 1'b1;
    repeat (3) wave(10, 10);
    repeat (5) tick();
    check("after_enable_pending", exp_q.size(), 0);

    // dropping en holds period and suppresses valid
    en = 1'b0;
    pend_ok = 1'b0;
    repeat (2) tick();
    check("en_drop_period_hold", period_o, 20);
    check("en_drop_locked", 32'(locked_o), 0);

`ifdef CLK_PERIOD_METER_LOCK_EN
    // lock: 20,21,19,20 locks after the 4th valid; 23 unlocks
    start_valid = 1'b0;
    en = 1'b1;
    tick();
    wave(10, 10);
    wave(10, 11);
    wave(10, 9);
    wave(10, 10);
    check("lock_not_yet", 32'(locked_o), 0);
    wave(10, 13);
    check("lock_after_4", 32'(locked_o), 1);
    wave(10, 10);
    check("lock_lost_23", 32'(locked_o), 0);
`endif

    repeat (10) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period of a slow, externally generated or divided clock (meas_clk) in cycles of the reference clock clk_in, reports each completed period, and flags loss of that clock. It is the observing end of the clock-divider path: the divider produces the clock and this block checks it. It is used for self-test of divided clocks and for monitoring clocks entering from off-chip.

## Interface
- TIMEOUT, default 1024: clk_in cycles without a meas_clk rising edge before the clock is declared lost. Range 4..2^32-1.
- EXP_PERIOD, default 20: expected period in clk_in cycles, equal to 2×CLOCK_DIVISOR of the source divider. Used only by the lock detector.
- TOL, default 1: allowed ±deviation from EXP_PERIOD in clk_in cycles. Lock detector only.
- LOCK_COUNT, default 4: consecutive in-tolerance periods required to assert locked. Lock detector only.
- clk_in, input, 1: reference clock. All logic runs on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- en, input, 1: measurement enable.
- meas_clk, input, 1: clock under measurement. Asynchronous to clk_in.
- period, output, 32: last completed period in clk_in cycles.
- period_valid, output, 1: one-cycle pulse when period updates.
- timeout, output, 1: meas_clk has been declared lost.
- locked, output, 1: measured period is stable and within tolerance.

## Operation
- meas_clk passes through a 2-FF synchronizer plus one history flop. rise = s2 & ~s3.
- Counter cnt is 32 bits. The FSM has three states: IDLE, MEASURE, LOST.
  - IDLE: cnt=0. On en & rise, cnt is set to 0 and the FSM goes to MEASURE. The first partial period is never reported.
  - MEASURE: cnt increments every cycle.
    - On rise: period<=cnt+1, period_valid<=1, cnt<=0.
    - If cnt==TIMEOUT-1 and there is no rise: go to LOST, timeout<=1, cnt<=0.
  - LOST: cnt is held at 0. On rise: timeout<=0 and go to MEASURE with cnt=0. No period is reported for that edge.
- If en drops in any state: go to IDLE next cycle. period and timeout hold their values. period_valid=0, locked<=0.
- rise on the same cycle as cnt==TIMEOUT-1: rise wins. The period is reported and there is no timeout.
- Reset values: period=0, period_valid=0, timeout=0, locked=0, state IDLE, synchronizer flops 0.
- Reset asserted mid-measurement: all state clears immediately. The next measurement restarts from IDLE.
- meas_clk must stay high and low for at least 2 clk_in cycles each. Faster input is outside the specified range and gives undefined period values.

## Timing
- Latency from a meas_clk rising edge to rise is 2–3 clk_in cycles, depending on sampling phase. period_valid asserts 1 cycle after rise.
- Synchronizer latency is the same on every edge, so it cancels in the measured period. Jitter is ±1 count.
- A steady meas_clk with period N gives period=N and period_valid every N cycles.
- timeout asserts exactly TIMEOUT cycles after the last rise, or after entry to MEASURE.

## Configuration
- CLK_PERIOD_METER_LOCK_EN defined: the lock detector is compiled in.
  - A match counter counts period_valid events with |period−EXP_PERIOD|≤TOL.
  - locked asserts in the cycle after the LOCK_COUNT-th consecutive match and stays set while periods continue to match.
  - Any out-of-tolerance period, timeout, or en low clears both locked and the match counter.
- Not defined: locked is tied to 0. EXP_PERIOD, TOL and LOCK_COUNT are ignored and no lock logic is synthesized.

## Structure
- Package clk_meter_pkg holds the state enum (IDLE, MEASURE, LOST) and the constant CNT_W=32.
- Sub-module sync_edge_det contains the 2-FF synchronizer, the history flop and the rise output. It is reusable for other asynchronous inputs.
- The top level holds the FSM, the counter, the output registers and the optional lock logic.

## Test plan
- Steady divided clock: drive meas_clk from a divider with CLOCK_DIVISOR=10 on clk_in. Required: period=20 on every period_valid after the first full period, with period_valid spaced 20 cycles apart.
- Lock: with CLK_PERIOD_METER_LOCK_EN, EXP_PERIOD=20, TOL=1, LOCK_COUNT=4, drive periods 20,21,19,20. Required: locked rises after the 4th valid. A following period of 23 drops locked to 0.
- Loss of clock: TIMEOUT=64, stop meas_clk after a rise. Required: timeout=1 and locked=0 exactly 64 cycles later, with no period_valid. On restart, timeout clears at the first rise and the next full period is reported.
- Boundary: a period of exactly 64 with TIMEOUT=64, so the rise coincides with cnt==63. Required: period=64 and timeout stays 0.
- Reset and enable: assert rst_n=0 mid-period. Required: all outputs 0 immediately. With en=0, toggling meas_clk produces no period_valid. After en=1, the first valid arrives only after two rises.
- Minimum pulse: meas_clk with 2 high and 2 low cycles. Required: period=4 on every period_valid.
